// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: IF-side push channel plus the decode-side output stage.
// master = fetch/decode environment, slave = the queue.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 3
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output if_valid, if_pc, if_inst,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst,
        output if_ready, id_valid, id_pc, id_inst, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry circular buffer feeding a registered decode stage; 2-cycle latency
// (1 cycle on empty queue with IF_ID_QUEUE_BYPASS_EN); if_ready drops only when full, decode stall holds id_*.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [5:0] stall,
    if_id_queue_if.slave q
);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;

    logic if_ready;
    logic push, adv, pop, empty, bypass, wr_en;
    logic unused_stall;

    assign unused_stall = ^{stall[5:3], stall[1:0]};

    // if_ready depends on occupancy only, so IF never sees a combinational path from stall.
    assign if_ready = (count_q != CNT_W'(DEPTH));
    assign push     = q.if_valid & if_ready;
    assign adv      = ~stall[2];
    assign empty    = (count_q == '0);
    assign pop      = adv & ~empty;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = adv & empty & push;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = push & ~bypass;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (adv) begin
            if (pop) begin
                id_valid_d = 1'b1;
                id_pc_d    = pc_mem_q[rd_ptr_q];
                id_inst_d  = inst_mem_q[rd_ptr_q];
            end else if (bypass) begin
                id_valid_d = 1'b1;
                id_pc_d    = q.if_pc;
                id_inst_d  = q.if_inst;
            end else begin
                id_valid_d = 1'b0;
                id_pc_d    = '0;
                id_inst_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    // Storage has no reset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (wr_en && !flush && !rst) begin
            pc_mem_q[wr_ptr_q]   <= q.if_pc;
            inst_mem_q[wr_ptr_q] <= q.if_inst;
        end
    end

    assign q.if_ready = if_ready;
    assign q.id_valid = id_valid_q;
    assign q.id_pc    = id_pc_q;
    assign q.id_inst  = id_inst_q;
    assign q.count    = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == CNT_W'(DEPTH)))
                else $error("push accepted while full");
            assert (count_q <= CNT_W'(DEPTH))
                else $error("count above DEPTH");
        end
    end
`endif

endmodule
